// File: rtl/rope_pkg.sv
// Shared types and frame geometry for the rope launcher and its neighbours.
package rope_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, FLYING, COOLDOWN} rope_state_t;

    localparam logic [10:0] FRAME_X_MAX = 11'd639;
    localparam logic [10:0] FRAME_Y_MAX = 11'd479;

    // Keeps a launch column on screen when the player stands near the right edge.
    function automatic logic [10:0] clamp_x(input logic [11:0] x);
        return (x > {1'b0, FRAME_X_MAX}) ? FRAME_X_MAX : x[10:0];
    endfunction

endpackage

// File: rtl/rope_launcher_if.sv
// Signals between the keyboard/player logic, the rope mover and the rope launcher.
interface rope_launcher_if;

    logic        startOfFrame;
    logic        gameActive;
    logic        fireKey;
    logic [10:0] playerX;
    logic        ropeMovingUp;
    logic [10:0] ropeTopY;
    logic        ballHit;

    logic        deploy;
    logic [10:0] ropeX;
    logic        ropeVisible;
    logic        hitPulse;
    logic [7:0]  shotCount;

    modport master (
        output startOfFrame, gameActive, fireKey, playerX, ropeMovingUp, ropeTopY, ballHit,
        input  deploy, ropeX, ropeVisible, hitPulse, shotCount
    );

    modport slave (
        input  startOfFrame, gameActive, fireKey, playerX, ropeMovingUp, ropeTopY, ballHit,
        output deploy, ropeX, ropeVisible, hitPulse, shotCount
    );

endinterface

// File: rtl/rope_launcher.sv
// Fire-control front end for the rope mover: one rope in flight, then a
// frame-counted cooldown that also waits for the mover to finish rising.
module rope_launcher
    import rope_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ROPE_X_OFFSET   = 16
) (
    input  logic          clk,
    input  logic          resetN,
    rope_launcher_if.slave bus
);

    localparam logic [7:0]  CNT_INIT = 8'(COOLDOWN_FRAMES);
    localparam logic [11:0] X_OFFSET = 12'(ROPE_X_OFFSET);

    rope_state_t r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_cut, w_cut_nxt;
    logic        r_fireD;
    logic        r_deploy, r_visible, r_hitPulse;
    logic [10:0] r_ropeX;
    logic [7:0]  r_shotCount;

    logic        w_fire_edge, w_hit_ok, w_launch, w_hit;
    logic [11:0] w_x_sum;

    assign w_fire_edge = bus.fireKey & ~r_fireD;
    // The mover reports topY at the bottom edge until the rope is actually drawn.
    assign w_hit_ok    = bus.ballHit && (bus.ropeTopY < FRAME_Y_MAX) && !r_cut;
    assign w_x_sum     = {1'b0, bus.playerX} + X_OFFSET;

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cut_nxt   = r_cut;
        w_launch    = 1'b0;
        w_hit       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fire_edge && bus.gameActive) begin
                    w_state_nxt = ARMED;
                    w_launch    = 1'b1;
                    w_cut_nxt   = 1'b0;
                end
            end
            ARMED: begin
                if (!bus.gameActive)       w_state_nxt = IDLE;
                else if (bus.startOfFrame) w_state_nxt = FLYING;
            end
            FLYING: begin
                // A hit outranks both the end-of-flight frame and a game stop.
                if (w_hit_ok) begin
                    w_hit       = 1'b1;
                    w_cut_nxt   = 1'b1;
                    w_state_nxt = COOLDOWN;
                    w_cnt_nxt   = CNT_INIT;
                end else if (!bus.gameActive || (bus.startOfFrame && !bus.ropeMovingUp)) begin
                    w_state_nxt = COOLDOWN;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            COOLDOWN: begin
                // A cut rope keeps rising in the mover; re-arming early would resume it.
                if (r_cnt == 8'd0 && !bus.ropeMovingUp)       w_state_nxt = IDLE;
                else if (bus.startOfFrame && r_cnt != 8'd0)   w_cnt_nxt   = r_cnt - 8'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_cut       <= 1'b0;
            r_fireD     <= 1'b0;
            r_deploy    <= 1'b0;
            r_visible   <= 1'b0;
            r_hitPulse  <= 1'b0;
            r_ropeX     <= 11'd0;
            r_shotCount <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cut      <= w_cut_nxt;
            r_fireD    <= bus.fireKey;
            r_deploy   <= (w_state_nxt == ARMED);
            r_visible  <= (w_state_nxt == FLYING) && !w_cut_nxt;
            r_hitPulse <= w_hit;
            if (w_launch) begin
                r_ropeX     <= clamp_x(w_x_sum);
                r_shotCount <= r_shotCount + 8'd1;
            end
        end
    end

    assign bus.deploy      = r_deploy;
    assign bus.ropeX       = r_ropeX;
    assign bus.ropeVisible = r_visible;
    assign bus.hitPulse    = r_hitPulse;
    assign bus.shotCount   = r_shotCount;

endmodule

// File: doc/rope_launcher.md
# rope_launcher

Fire-control front end for the rope mover. It turns the player's fire key into the `deploy` request the mover consumes and latches the rope's X column at launch. It tracks the flight by watching the mover's `movingUp`/`topY` returns, and gates rope visibility when a ball hit cuts the rope. It sits between the keyboard/player logic and the rope mover, and enforces one rope in flight plus a frame-counted cooldown.

## Interface
- `COOLDOWN_FRAMES`, 8: frames to wait after a rope ends before re-arming (1..255).
- `ROPE_X_OFFSET`, 16: added to `playerX` to give the rope column.
- `clk` input 1: system clock.
- `resetN` input 1: reset, asynchronous, active-low.
- `startOfFrame` input 1: one-cycle pulse per frame (30 Hz).
- `gameActive` input 1: launches are allowed only while high.
- `fireKey` input 1: level from the key decoder, synchronous to `clk`.
- `playerX` input 11: player left X, in pixels.
- `ropeMovingUp` input 1: the mover's `movingUp`.
- `ropeTopY` input 11: the mover's `topY`, in pixels.
- `ballHit` input 1: one-cycle pulse from rope/ball collision.
- `deploy` output 1: request to the mover.
- `ropeX` output 11: latched rope column.
- `ropeVisible` output 1: draw enable for the rope object.
- `hitPulse` output 1: one-cycle pulse to the score logic.
- `shotCount` output 8: number of launches, wraps at 255→0.

## Operation
- Fire detect: `fireKey` is registered into `fireD`. `fireEdge = fireKey & ~fireD`. Key holds do not auto-repeat.
- FSM states: IDLE, ARMED, FLYING, COOLDOWN.
- IDLE → ARMED on `fireEdge & gameActive`.
  - On that transition, latch `ropeX <= playerX + ROPE_X_OFFSET`. The result is 11-bit and saturates at 639.
  - Increment `shotCount`.
  - A `fireEdge` in any other state is dropped. It is not queued.
- ARMED:
  - `deploy` = 1 for the whole state.
  - On `startOfFrame`, go to FLYING. The mover moves on that same edge.
- FLYING:
  - `ropeVisible` = 1 unless the `cut` flag is set.
  - `ballHit` sets `cut`, fires `hitPulse` for 1 cycle, and moves to COOLDOWN. Only the first hit per shot scores.
  - `startOfFrame` with `ropeMovingUp` = 0 means the rope has passed the top. Go to COOLDOWN with no hit.
  - `ropeTopY` is used only by the `ballHit` qualifier: a hit is ignored when `ropeTopY >= 479`, because the rope is not yet drawn.
- COOLDOWN:
  - On entry, load `cnt = COOLDOWN_FRAMES`.
  - Decrement `cnt` on each `startOfFrame`.
  - Go to IDLE when `cnt == 0` and `ropeMovingUp == 0`. A cut rope is still rising in the mover, and re-deploying early would continue the old rope.
- `gameActive` falling:
  - In ARMED, return to IDLE and drop `deploy`. The shot is already counted.
  - In FLYING, go to COOLDOWN.
- `cnt` is 8-bit and never underflows: it holds at 0.

## Timing
- Reset values: `deploy` 0, `ropeX` 0, `ropeVisible` 0, `hitPulse` 0, `shotCount` 0. FSM in IDLE, `cnt` 0, `cut` 0, `fireD` 0.
- Every output is registered, giving 1 cycle of latency from the causing input edge.
- `deploy` rises on the cycle after `fireEdge`. It falls on the cycle after the `startOfFrame` that is sampled in ARMED.
  - If `fireEdge` and `startOfFrame` coincide in IDLE, the launch waits for the next frame.
- `hitPulse` is exactly 1 cycle, 1 cycle after `ballHit`.
- `ballHit` and the end-of-flight `startOfFrame` in the same cycle: the hit wins and `hitPulse` fires.
- Worst-case fire-to-rope-motion latency is 1 frame plus 2 cycles.
- Reset mid-flight returns everything to the reset values immediately. The mover is reset by the same `resetN`.

## Structure
- Shared package `rope_pkg`:
  - `typedef enum logic [1:0] {IDLE, ARMED, FLYING, COOLDOWN} rope_state_t`.
  - Constants `FRAME_X_MAX = 639` and `FRAME_Y_MAX = 479`.
- Single module with no sub-modules. The edge detector is inline.

## Test plan
- Launch: `playerX` = 100, fire at cycle 10, `startOfFrame` at cycle 50.
  - `deploy` high on cycles 11..50 and low from 51.
  - `ropeX` = 116, `shotCount` = 1, `ropeVisible` = 1 from 51.
- Full flight: with the mover attached (`Yspeed` −150), the rope reaches the top.
  - FLYING ends at the first frame with `movingUp` = 0.
  - IDLE is reached 8 frames later.
  - A fire during COOLDOWN is ignored: `shotCount` stays 1.
- Hit: `ballHit` pulse while FLYING with `ropeTopY` = 300.
  - `hitPulse` is 1 cycle and `ropeVisible` = 0 next cycle.
  - A second `ballHit` gives no pulse.
  - IDLE is not reached before the mover's `movingUp` = 0, even after 8 frames.
- Key hold: `fireKey` held high for 200 frames gives exactly 1 launch.
- Clamp: `playerX` = 630 gives `ropeX` = 639.
- Aborts:
  - `gameActive` falling in ARMED → IDLE with `deploy` low next cycle.
  - `resetN` pulsed mid-FLYING → all outputs return to 0 asynchronously.
